// File: rtl/sequence_ctrl.sv
// Step sequencer controller: records switch values into block RAM
// and loops them back out to the LEDs.
module sequence_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int MEM_DEPTH  = 8,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rec_btn,
    input  logic                  play_btn,
    input  logic                  step_tick,
    input  logic [DATA_WIDTH-1:0] sw_data,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_r_en,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [DATA_WIDTH-1:0] led,
    output logic                  recording,
    output logic                  playing
);

    typedef enum logic [1:0] {
        IDLE,
        RECORD,
        PLAY
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state, state_n;
    logic [ADDR_WIDTH:0]   seq_len, seq_len_n;
    logic [ADDR_WIDTH-1:0] idx, idx_n;
    logic                  rd_valid, rd_valid_n;
    logic                  w_en_n, r_en_n;
    logic [ADDR_WIDTH-1:0] w_addr_n, r_addr_n;
    logic [DATA_WIDTH-1:0] w_data_n, led_n;
    logic                  recording_n, playing_n;

    always_comb begin
        state_n    = state;
        seq_len_n  = seq_len;
        idx_n      = idx;
        w_en_n     = 1'b0;
        w_addr_n   = mem_w_addr;
        w_data_n   = mem_w_data;
        r_en_n     = 1'b0;
        r_addr_n   = mem_r_addr;
        rd_valid_n = mem_r_en;
        led_n      = rd_valid ? mem_r_data : led;
        unique case (state)
            IDLE: begin
                if (rec_btn) begin
                    state_n   = RECORD;
                    idx_n     = '0;
                    seq_len_n = '0;
                end else if (play_btn && seq_len != '0) begin
                    state_n = PLAY;
                    idx_n   = '0;
                end
            end
            RECORD: begin
                if (rec_btn) begin
                    state_n = IDLE;
                end else if (step_tick) begin
                    w_en_n    = 1'b1;
                    w_addr_n  = idx;
                    w_data_n  = sw_data;
                    idx_n     = idx + 1'b1;
                    seq_len_n = seq_len + 1'b1;
                    if (idx == LAST) state_n = IDLE;
                end
            end
            PLAY: begin
                // stopping drops whatever read is still in flight
                if (play_btn) begin
                    state_n    = IDLE;
                    led_n      = '0;
                    rd_valid_n = 1'b0;
                end else if (step_tick) begin
                    r_en_n   = 1'b1;
                    r_addr_n = idx;
                    if ({1'b0, idx} == seq_len - 1'b1) idx_n = '0;
                    else idx_n = idx + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        recording_n = (state_n == RECORD);
        playing_n   = (state_n == PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            seq_len    <= '0;
            idx        <= '0;
            rd_valid   <= 1'b0;
            mem_w_en   <= 1'b0;
            mem_w_addr <= '0;
            mem_w_data <= '0;
            mem_r_en   <= 1'b0;
            mem_r_addr <= '0;
            led        <= '0;
            recording  <= 1'b0;
            playing    <= 1'b0;
        end else begin
            state      <= state_n;
            seq_len    <= seq_len_n;
            idx        <= idx_n;
            rd_valid   <= rd_valid_n;
            mem_w_en   <= w_en_n;
            mem_w_addr <= w_addr_n;
            mem_w_data <= w_data_n;
            mem_r_en   <= r_en_n;
            mem_r_addr <= r_addr_n;
            led        <= led_n;
            recording  <= recording_n;
            playing    <= playing_n;
        end
    end

endmodule

// File: tb/tb_sequence_ctrl.sv
// Bench for sequence_ctrl: behavioural pattern model with a
// cycle-by-cycle compare, plus directed and random stimulus.
module tb_sequence_ctrl;

    localparam int DW = 4;
    localparam int DEPTH = 8;
    localparam int AW = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst, rec_btn, play_btn, step_tick;
    logic [DW-1:0] sw_data;
    logic          mem_w_en, mem_r_en;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, mem_r_data, led;
    logic          recording, playing;

    sequence_ctrl #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .rec_btn(rec_btn), .play_btn(play_btn),
        .step_tick(step_tick), .sw_data(sw_data),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data), .mem_r_en(mem_r_en),
        .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
        .led(led), .recording(recording), .playing(playing)
    );

    always #5 clk = ~clk;

    // attached dual-port RAM with registered read
    logic [DW-1:0] ram [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_w_addr] <= mem_w_data;
        if (mem_r_en) mem_r_data <= ram[mem_r_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: mode 0 idle, 1 record, 2 play; pattern kept as plain array
    typedef struct { int due; int val; } ev_t;
    int   mode = 0;
    int   pat [DEPTH];
    int   len = 0;
    int   pos = 0;
    int   cyc = 0;
    ev_t  q [$];
    int   led_log [$];
    int   raddr_log [$];
    int   waddr_log [$];
    int   e_wen = 0, e_waddr = 0, e_wdata = 0;
    int   e_ren = 0, e_raddr = 0;
    int   e_led = 0, e_rec = 0, e_play = 0;
    bit   chk_en = 0;

    always @(posedge clk) begin
        bit stop;
        cyc++;
        if (rst) begin
            mode = 0; len = 0; pos = 0; q.delete();
            e_wen = 0; e_waddr = 0; e_wdata = 0;
            e_ren = 0; e_raddr = 0;
            e_led = 0; e_rec = 0; e_play = 0;
        end else begin
            e_wen = 0;
            e_ren = 0;
            stop = (mode == 2) && play_btn;
            if (!stop)
                while (q.size() > 0 && q[0].due == cyc) begin
                    e_led = q[0].val;
                    led_log.push_back(e_led);
                    void'(q.pop_front());
                end
            case (mode)
                0: begin
                    if (rec_btn) begin
                        mode = 1; pos = 0; len = 0; e_rec = 1;
                    end else if (play_btn && len != 0) begin
                        mode = 2; pos = 0; e_play = 1;
                    end
                end
                1: begin
                    if (rec_btn) begin
                        mode = 0; e_rec = 0;
                    end else if (step_tick) begin
                        e_wen = 1; e_waddr = pos; e_wdata = int'(sw_data);
                        waddr_log.push_back(pos);
                        pat[pos] = int'(sw_data);
                        pos++; len++;
                        if (len == DEPTH) begin
                            mode = 0; e_rec = 0;
                        end
                    end
                end
                default: begin
                    if (stop) begin
                        mode = 0; e_play = 0; e_led = 0; q.delete();
                    end else if (step_tick) begin
                        e_ren = 1; e_raddr = pos;
                        raddr_log.push_back(pos);
                        q.push_back('{due: cyc + 2, val: pat[pos]});
                        pos = (pos + 1) % len;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("w_en", int'(mem_w_en), e_wen);
            if (e_wen != 0) begin
                chk("w_addr", int'(mem_w_addr), e_waddr);
                chk("w_data", int'(mem_w_data), e_wdata);
            end
            chk("r_en", int'(mem_r_en), e_ren);
            if (e_ren != 0) chk("r_addr", int'(mem_r_addr), e_raddr);
            chk("led", int'(led), e_led);
            chk("recording", int'(recording), e_rec);
            chk("playing", int'(playing), e_play);
            if (mem_w_en && mem_r_en) chk("w_r_excl", 1, 0);
        end
    end

    task automatic drive(input logic r, input logic p, input logic t,
                         input logic [DW-1:0] s, input logic x);
        @(negedge clk);
        rec_btn = r; play_btn = p; step_tick = t; sw_data = s; rst = x;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 4'h0, 0);
    endtask

    initial begin
        int exp_led [7];
        int exp_ra [7];
        exp_led = '{1, 2, 4, 1, 2, 4, 1};
        exp_ra  = '{0, 1, 2, 0, 1, 2, 0};
        rst = 1; rec_btn = 0; play_btn = 0; step_tick = 0; sw_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_w_en", int'(mem_w_en), 0);
        chk("rst_r_en", int'(mem_r_en), 0);
        chk("rst_addrs", int'({mem_w_addr, mem_r_addr}), 0);
        chk("rst_w_data", int'(mem_w_data), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_flags", int'({recording, playing}), 0);
        chk_en = 1;
        drive(0, 1, 0, 4'h0, 0);
        idle(2);
        chk("play_ignored", int'(playing), 0);

        drive(1, 0, 0, 4'h0, 0);
        drive(0, 0, 1, 4'h1, 0);
        drive(0, 0, 1, 4'h2, 0);
        drive(0, 0, 1, 4'h4, 0);
        idle(1);
        drive(1, 0, 0, 4'h0, 0);
        idle(2);
        chk("short_len", len, 3);
        chk("short_writes", waddr_log.size(), 3);
        chk("short_pat", pat[0] * 100 + pat[1] * 10 + pat[2], 124);

        led_log.delete(); raddr_log.delete();
        drive(0, 1, 0, 4'h0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 4'h0, 0);
            if (i % 2 == 0) idle(1);
        end
        idle(4);
        chk("wrap_led_cnt", led_log.size(), 7);
        chk("wrap_ra_cnt", raddr_log.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < led_log.size()) chk("wrap_led", led_log[i], exp_led[i]);
            if (i < raddr_log.size()) chk("wrap_raddr", raddr_log[i], exp_ra[i]);
        end
        drive(0, 1, 0, 4'h0, 0);
        idle(2);

        waddr_log.delete();
        drive(1, 0, 0, 4'h0, 0);
        for (int i = 0; i < 9; i++) drive(0, 0, 1, 4'(i), 0);
        idle(2);
        chk("full_writes", waddr_log.size(), 8);
        chk("full_len", len, 8);
        chk("full_mode", mode, 0);
        chk("full_last", waddr_log.size() > 0 ? waddr_log[$] : -1, 7);

        waddr_log.delete();
        drive(1, 0, 0, 4'h0, 0);
        drive(0, 0, 1, 4'h3, 0);
        drive(1, 0, 1, 4'h5, 0);
        idle(2);
        chk("sim_rec_tick", waddr_log.size(), 1);
        chk("sim_mode", mode, 0);
        drive(1, 1, 0, 4'h0, 0);
        idle(1);
        chk("rec_beats_play", mode, 1);
        drive(0, 0, 1, 4'h9, 0);
        drive(0, 0, 1, 4'h6, 0);
        drive(1, 0, 0, 4'h0, 0);
        idle(2);

        led_log.delete();
        drive(0, 1, 0, 4'h0, 0);
        drive(0, 0, 1, 4'h0, 0);
        drive(0, 1, 0, 4'h0, 0);
        idle(4);
        chk("stop_no_led", led_log.size(), 0);
        chk("stop_led", int'(led), 0);

        drive(0, 1, 0, 4'h0, 0);
        drive(0, 0, 1, 4'h0, 0);
        drive(0, 0, 1, 4'h0, 0);
        drive(0, 0, 0, 4'h0, 1);
        drive(0, 1, 0, 4'h0, 0);
        idle(3);
        chk("abort_len", len, 0);
        chk("abort_playing", int'(playing), 0);

        for (int i = 0; i < 4000; i++)
            drive($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 2) == 0, 4'($urandom),
                  $urandom_range(0, 599) == 0);
        idle(4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
